// File: rtl/cnn_mem_pkg.sv
// Constants and state encoding shared by the CNN loader, convolution and feature buffer blocks.
package cnn_mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 17;
  localparam int DEPTH_DEF  = 129054;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/feature_mem_if.sv
// Access/clear bus of the feature buffer: master drives requests, slave returns read data and status.
interface feature_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 17
);
  logic              en;
  logic              wr;
  logic [ADDR_W-1:0] addrin;
  logic [DATA_W-1:0] datain;
  logic              clr;
  logic [DATA_W-1:0] dataout;
  logic              dout_valid;
  logic              addr_err;
  logic              busy;
  logic              clr_done;

  modport master (
    output en, wr, addrin, datain, clr,
    input  dataout, dout_valid, addr_err, busy, clr_done
  );

  modport slave (
    input  en, wr, addrin, datain, clr,
    output dataout, dout_valid, addr_err, busy, clr_done
  );
endinterface

// File: rtl/feature_mem_clear_ctrl.sv
// Clear sequencer: sweeps a zero write over addresses 0..DEPTH-1, one word per cycle.
//   state    | meaning
//   ST_IDLE  | normal accesses allowed, waiting for clr
//   ST_CLEAR | writing zero to r_cnt each cycle, busy=1
module feature_mem_clear_ctrl
  import cnn_mem_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IDX_W  = ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  output logic             o_busy,
  output logic             o_clr_done,
  output logic             o_clr_we,
  output logic [IDX_W-1:0] o_clr_addr
);
  clr_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic              r_done, w_done_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Terminal compare against DEPTH-1 keeps the counter inside the array for non-power-of-2 depths.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_clr) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        if (r_cnt == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_busy     = (r_state == ST_CLEAR);
  assign o_clr_we   = (r_state == ST_CLEAR);
  assign o_clr_addr = r_cnt[IDX_W-1:0];
  assign o_clr_done = r_done;

endmodule

// File: rtl/feature_mem.sv
// Single-port feature buffer with registered read, optional output stage and a hardware clear sweep.
module feature_mem
  import cnn_mem_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int OUT_REG = 0
) (
  input logic          clk,
  input logic          rst,
  feature_mem_if.slave bus
);
  localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic             w_busy, w_clr_done, w_clr_we;
  logic [IDX_W-1:0] w_clr_addr;
  logic             w_acc, w_rd, w_in_range, w_we;
  logic [IDX_W-1:0] w_widx, w_ridx;
  logic [DATA_W-1:0] w_wdata;

  logic [DATA_W-1:0] r_dout1;
  logic              r_valid1, r_err1;

  feature_mem_clear_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_clear_ctrl (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (bus.clr),
    .o_busy     (w_busy),
    .o_clr_done (w_clr_done),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  // clr takes priority over a same-cycle access.
  assign w_acc      = bus.en & ~w_busy & ~bus.clr;
  assign w_rd       = w_acc & ~bus.wr;
  assign w_in_range = ({1'b0, bus.addrin} < (ADDR_W + 1)'(DEPTH));
  assign w_ridx     = bus.addrin[IDX_W-1:0];

  assign w_we    = ~rst & (w_clr_we | (w_acc & bus.wr & w_in_range));
  assign w_widx  = w_clr_we ? w_clr_addr : bus.addrin[IDX_W-1:0];
  assign w_wdata = w_clr_we ? '0 : bus.datain;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_widx] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout1  <= '0;
      r_valid1 <= 1'b0;
      r_err1   <= 1'b0;
    end else begin
      r_valid1 <= w_rd;
      r_err1   <= w_acc & ~w_in_range;
      if (w_rd) r_dout1 <= w_in_range ? r_mem[w_ridx] : '0;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] r_dout2;
      logic              r_valid2, r_err2;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_dout2  <= '0;
          r_valid2 <= 1'b0;
          r_err2   <= 1'b0;
        end else begin
          r_valid2 <= r_valid1;
          r_err2   <= r_err1;
          if (r_valid1) r_dout2 <= r_dout1;
        end
      end

      assign bus.dataout    = r_dout2;
      assign bus.dout_valid = r_valid2;
      assign bus.addr_err   = r_err2;
    end else begin : g_no_out_reg
      assign bus.dataout    = r_dout1;
      assign bus.dout_valid = r_valid1;
      assign bus.addr_err   = r_err1;
    end
  endgenerate

  assign bus.busy     = w_busy;
  assign bus.clr_done = w_clr_done;

endmodule

// File: tb/tb_feature_mem.sv
// Scoreboard bench driving one OUT_REG=0 and one OUT_REG=1 instance with identical stimulus.
module tb_feature_mem;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0, wr = 1'b0, clr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din = '0;

  always #5 clk = ~clk;

  feature_mem_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
  feature_mem_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

  assign if0.en = en;   assign if0.wr = wr;   assign if0.addrin = addr;
  assign if0.datain = din; assign if0.clr = clr;
  assign if1.en = en;   assign if1.wr = wr;   assign if1.addrin = addr;
  assign if1.datain = din; assign if1.clr = clr;

  feature_mem #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  feature_mem #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave));

  typedef struct {
    int          due;
    logic [DW-1:0] data;
    bit          valid;
    bit          err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic compare(input int id, input exp_t x, input logic v, input logic e,
                         input logic [DW-1:0] d);
    n_cmp++;
    if (x.due != cyc || v !== x.valid || e !== x.err || (x.valid && d !== x.data)) begin
      n_bad++;
      $display("FAIL out%0d: got cyc=%0d valid=%b err=%b data=%h, want cyc=%0d valid=%b err=%b data=%h",
               id, cyc, v, e, d, x.due, x.valid, x.err, x.data);
    end
  endtask

  task automatic missing(input int id, input exp_t x);
    n_cmp++;
    n_bad++;
    $display("FAIL missing%0d: got no output by cyc=%0d, want valid=%b err=%b data=%h at cyc=%0d",
             id, cyc, x.valid, x.err, x.data, x.due);
  endtask

  task automatic unexpected(input int id, input logic v, input logic e, input logic [DW-1:0] d);
    n_cmp++;
    n_bad++;
    $display("FAIL spurious%0d: got valid=%b err=%b data=%h at cyc=%0d, want no output",
             id, v, e, d, cyc);
  endtask

  always @(negedge clk) begin
    exp_t x;
    while (q0.size() > 0 && q0[0].due < cyc) begin
      x = q0.pop_front();
      missing(0, x);
    end
    if (if0.dout_valid || if0.addr_err) begin
      if (q0.size() == 0) unexpected(0, if0.dout_valid, if0.addr_err, if0.dataout);
      else begin
        x = q0.pop_front();
        compare(0, x, if0.dout_valid, if0.addr_err, if0.dataout);
      end
    end
  end

  always @(negedge clk) begin
    exp_t x;
    while (q1.size() > 0 && q1[0].due < cyc) begin
      x = q1.pop_front();
      missing(1, x);
    end
    if (if1.dout_valid || if1.addr_err) begin
      if (q1.size() == 0) unexpected(1, if1.dout_valid, if1.addr_err, if1.dataout);
      else begin
        x = q1.pop_front();
        compare(1, x, if1.dout_valid, if1.addr_err, if1.dataout);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; wr = 1'b0; clr = 1'b0;
  endtask

  // Expected slot: sampled at the next edge, visible one (or two) edges later.
  task automatic push(input logic [DW-1:0] d, input bit v, input bit e);
    exp_t x;
    x.data = d; x.valid = v; x.err = e;
    x.due = cyc + 1; q0.push_back(x);
    x.due = cyc + 2; q1.push_back(x);
  endtask

  task automatic acc_wr(input int a, input logic [DW-1:0] d);
    en = 1'b1; wr = 1'b1; clr = 1'b0; addr = AW'(a); din = d;
    if (a >= DP) push('0, 1'b0, 1'b1);
    step();
  endtask

  task automatic acc_rd(input int a, input logic [DW-1:0] expd);
    en = 1'b1; wr = 1'b0; clr = 1'b0; addr = AW'(a);
    if (a >= DP) push('0, 1'b1, 1'b1);
    else push(expd, 1'b1, 1'b0);
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      step();
    end
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    step();
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, " outs0"}, {if0.dataout, if0.dout_valid, if0.addr_err, if0.busy, if0.clr_done}, '0);
    chk({tag, " outs1"}, {if1.dataout, if1.dout_valid, if1.addr_err, if1.busy, if1.clr_done}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nb0, nb1, nd0, nd1, first_b, last_b, done_at;

    rst = 1'b1;
    repeat (3) step();
    chk_outs_zero("reset");
    rst = 1'b0;
    step();

    // fill and back-to-back readback
    for (int a = 0; a < DP; a++) acc_wr(a, 32'hDEAD0000 + a);
    for (int a = 0; a < DP; a++) acc_rd(a, 32'hDEAD0000 + a);
    idle();
    drain();

    // write followed immediately by read of the same address
    acc_wr(5, 32'h12345678);
    acc_rd(5, 32'h12345678);
    idle();
    drain();

    // out-of-range read and write, then array unchanged
    acc_rd(20, '0);
    acc_wr(17, 32'hFFFF_FFFF);
    for (int a = 0; a < DP; a++) acc_rd(a, (a == 5) ? 32'h12345678 : 32'hDEAD0000 + a);
    idle();
    drain();

    // clear sweep with a colliding access and accesses during busy
    for (int a = 0; a < DP; a++) acc_wr(a, 32'h5A000000 + a);
    en = 1'b1; wr = 1'b1; addr = AW'(20); din = '1; clr = 1'b1;
    step();
    nb0 = 0; nb1 = 0; nd0 = 0; nd1 = 0; first_b = -1; last_b = -1; done_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (if0.busy) begin
        nb0++;
        if (first_b < 0) first_b = i;
        last_b = i;
      end
      if (if1.busy) nb1++;
      if (if0.clr_done) begin nd0++; done_at = i; end
      if (if1.clr_done) nd1++;
      clr  = (i == 8);
      en   = (i < 15);
      wr   = i[0];
      addr = AW'(i);
      din  = 32'h00000BAD;
      step();
    end
    idle();
    chk("busy cycles0", 64'(nb0), 64'd16);
    chk("busy cycles1", 64'(nb1), 64'd16);
    chk("busy first", 64'(first_b), 64'd0);
    chk("busy last", 64'(last_b), 64'd15);
    chk("clr_done pulses0", 64'(nd0), 64'd1);
    chk("clr_done pulses1", 64'(nd1), 64'd1);
    chk("clr_done slot", 64'(done_at), 64'd16);
    for (int a = 0; a < DP; a++) acc_rd(a, '0);
    idle();
    drain();

    // reset aborts a sweep after six zero writes
    for (int a = 0; a < DP; a++) acc_wr(a, 32'hC0DE0000 + a);
    idle();
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (6) step();
    chk("busy before abort", {63'd0, if0.busy}, 64'd1);
    rst = 1'b1;
    step();
    chk("abort busy0", {63'd0, if0.busy}, 64'd0);
    chk("abort busy1", {63'd0, if1.busy}, 64'd0);
    chk("abort done0", {63'd0, if0.clr_done}, 64'd0);
    chk("abort done1", {63'd0, if1.clr_done}, 64'd0);
    rst = 1'b0;
    nd0 = 0;
    for (int i = 0; i < 20; i++) begin
      if (if0.clr_done || if1.clr_done || if0.busy || if1.busy) nd0++;
      step();
    end
    chk("no done after abort", 64'(nd0), 64'd0);
    for (int a = 0; a < DP; a++) acc_rd(a, (a < 6) ? 32'h0 : 32'hC0DE0000 + a);
    idle();
    drain();

    // reset clears held dataout
    rst = 1'b1;
    step();
    chk_outs_zero("re-reset");
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
